sifh_hist_reader: RTL and testbench
===================================

Name: sifh_hist_reader

Overview:
Readout side of the SiFH histogram RAM: after the histogram FSM has accumulated photon counts, this block sweeps every bin of every pixel histogram through RAM port b. It finds the per-pixel peak bin (time-of-flight estimate) and optionally clears each bin through port a for the next frame. One result per pixel is handed downstream over a valid/ready interface.

Parameters:
NB, 10, RAM address width
PEAK_MAX, 8, bin count width (RAM data width)
BIN_NUM_PER_HIS, 64, bins per pixel histogram
PIXEL_NUM_PER_RAM, 16, pixel histograms stored per RAM
PIX_W, 4, pixel index width, clog2(PIXEL_NUM_PER_RAM)
BIN_W, 6, bin index width, clog2(BIN_NUM_PER_HIS)

Ports:
clk  in  1  system clock, all logic on rising edge
res  in  1  reset, synchronous, active-low
start  in  1  one-cycle request to read out all pixels; ignored while busy
clear_en  in  1  sampled with start; 1 = zero each bin after reading
threshold  in  PEAK_MAX  minimum peak count for a valid hit; sampled with start
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after last pixel result is accepted
raddr  out  NB  port b address
rEnable  out  1  port b read enable, active high
readFlag  out  1  port b memory enable
counts  in  PEAK_MAX  port b read data, valid 1 cycle after rEnable
waddr  out  NB  port a address
wEnable  out  1  port a write enable, active high
writeFlag  out  1  port a memory enable
newCounts  out  PEAK_MAX  port a write data (always 0 when writing)
peak_valid  out  1  result valid
peak_ready  in  1  downstream accepts result
peak_pixel  out  PIX_W  pixel index of result
peak_bin  out  BIN_W  bin index of maximum count
peak_count  out  PEAK_MAX  maximum count
peak_hit  out  1  1 when peak_count >= threshold

Behaviour:
- Reset (res low at clk edge): state IDLE. Every output is 0: busy, done, raddr, rEnable, readFlag, waddr, wEnable, writeFlag, newCounts, peak_*. Internal pixel/bin counters and running max are also 0. If reset lands mid-operation, the partial pixel is discarded, with no result emitted and no further writes.
- RAM address = pixel*BIN_NUM_PER_HIS + bin; must fit in NB.
- States: IDLE, SCAN, DRAIN, EMIT, DONE.
- IDLE: start=1 -> latch clear_en and threshold, pixel=0, bin=0, busy=1, go to SCAN.
- SCAN: each cycle drive rEnable=readFlag=1 and raddr=addr(pixel,bin), then bin++. The cycle that issues bin BIN_NUM_PER_HIS-1 goes to DRAIN. There are no bubbles: BIN_NUM_PER_HIS consecutive reads.
- Data pipeline: delayed-valid and delayed-bin registers track each read. In the cycle its counts arrives, the first bin of a pixel loads max/bin unconditionally. Later bins replace them only if counts > max (strictly greater, so a tie keeps the lowest bin).
- Clear: if latched clear_en=1, in the cycle counts arrives drive wEnable=writeFlag=1, waddr = that bin's address, newCounts=0. Otherwise port a stays idle.
- DRAIN: one cycle with no read issued. It receives the last datum, finishes the compare and performs the last clear write. Then go to EMIT.
- EMIT: peak_valid=1 with peak_pixel, peak_bin, peak_count, peak_hit held stable until peak_ready=1.
  - On the handshake cycle, if pixel = PIXEL_NUM_PER_RAM-1, go to DONE.
  - Otherwise pixel++, bin=0, go to SCAN.
  - No RAM access occurs during EMIT.
  - peak_valid drops the cycle after the handshake.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Per-pixel latency: BIN_NUM_PER_HIS+1 cycles from first read to peak_valid, plus any stall.
- Counts at all-ones (saturated) compare normally; there is no overflow, because the block never adds.
- start while busy: ignored, with no effect on latched clear_en or threshold.

Test Plan:
Use BIN_NUM_PER_HIS=8, PIXEL_NUM_PER_RAM=2, NB=4, PEAK_MAX=8, peak_ready=1 unless stated.
1. Single peak: pixel0 bins 0,1,9,3,0,0,0,0 and pixel1 bin5=200, threshold=4 -> (pixel0, bin2, count9, hit1), then (pixel1, bin5, count200, hit1), then done pulse once.
2. Tie: pixel0 bins 1 and 6 both =5, others 0 -> peak_bin=1, peak_count=5.
3. Backpressure: peak_ready low 5 cycles in EMIT -> peak_* stable, rEnable=wEnable=0 throughout; pixel1 reads start the cycle after handshake.
4. Clear: clear_en=1 -> exactly 16 writes of newCounts=0 to addresses 0..15, each one cycle after the read of the same address; RAM all zero afterwards. With clear_en=0 -> zero writes.
5. Threshold: all-zero histogram except bin7=3, threshold=4 -> peak_bin=7, peak_count=3, peak_hit=0. All-zero histogram -> peak_bin=0, count 0.
6. Reset mid-scan at pixel1 bin3 -> all outputs 0 the next cycle, no peak_valid. A new start reports pixel0 first; start pulsed during busy is ignored.

Source files
------------

// File: rtl/sifh_hist_reader_if.sv
// Bus bundle for the histogram reader: RAM port b (read), RAM port a (clear)
// and the per-pixel peak result stream.
interface sifh_hist_reader_if #(
    parameter int NB       = 10,
    parameter int PEAK_MAX = 8,
    parameter int PIX_W    = 4,
    parameter int BIN_W    = 6
);
    logic [NB-1:0]       raddr;
    logic                rEnable;
    logic                readFlag;
    logic [PEAK_MAX-1:0] counts;
    logic [NB-1:0]       waddr;
    logic                wEnable;
    logic                writeFlag;
    logic [PEAK_MAX-1:0] newCounts;
    logic                peak_valid;
    logic                peak_ready;
    logic [PIX_W-1:0]    peak_pixel;
    logic [BIN_W-1:0]    peak_bin;
    logic [PEAK_MAX-1:0] peak_count;
    logic                peak_hit;

    modport master (
        output raddr, rEnable, readFlag, waddr, wEnable, writeFlag, newCounts,
        output peak_valid, peak_pixel, peak_bin, peak_count, peak_hit,
        input  counts, peak_ready
    );

    modport slave (
        input  raddr, rEnable, readFlag, waddr, wEnable, writeFlag, newCounts,
        input  peak_valid, peak_pixel, peak_bin, peak_count, peak_hit,
        output counts, peak_ready
    );
endinterface

// File: rtl/sifh_hist_reader.sv
// Sweeps every bin of every pixel histogram, reports the per-pixel peak bin
// and optionally zeroes each bin behind the read.
module sifh_hist_reader #(
    parameter int NB                = 10,
    parameter int PEAK_MAX          = 8,
    parameter int BIN_NUM_PER_HIS   = 64,
    parameter int PIXEL_NUM_PER_RAM = 16,
    parameter int PIX_W             = 4,
    parameter int BIN_W             = 6
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic                clear_en,
    input  logic [PEAK_MAX-1:0] threshold,
    output logic                busy,
    output logic                done,
    sifh_hist_reader_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BIN_NUM_PER_HIS - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM_PER_RAM - 1);

    state_t              state_q, state_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                clr_q, clr_d;
    logic [PEAK_MAX-1:0] thr_q, thr_d;
    logic                vld_q, vld_d;
    logic [BIN_W-1:0]    dbin_q, dbin_d;
    logic [PEAK_MAX-1:0] max_q, max_d;
    logic [BIN_W-1:0]    mbin_q, mbin_d;

    function automatic logic [NB-1:0] bin_addr(input logic [PIX_W-1:0] p,
                                               input logic [BIN_W-1:0] b);
        return NB'(p) * NB'(BIN_NUM_PER_HIS) + NB'(b);
    endfunction

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            bin_q   <= '0;
            clr_q   <= 1'b0;
            thr_q   <= '0;
            vld_q   <= 1'b0;
            dbin_q  <= '0;
            max_q   <= '0;
            mbin_q  <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            bin_q   <= bin_d;
            clr_q   <= clr_d;
            thr_q   <= thr_d;
            vld_q   <= vld_d;
            dbin_q  <= dbin_d;
            max_q   <= max_d;
            mbin_q  <= mbin_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pix_d          = pix_q;
        bin_d          = bin_q;
        clr_d          = clr_q;
        thr_d          = thr_q;
        vld_d          = 1'b0;
        dbin_d         = dbin_q;
        max_d          = max_q;
        mbin_d         = mbin_q;
        busy           = 1'b0;
        done           = 1'b0;
        bus.raddr      = '0;
        bus.rEnable    = 1'b0;
        bus.readFlag   = 1'b0;
        bus.waddr      = '0;
        bus.wEnable    = 1'b0;
        bus.writeFlag  = 1'b0;
        bus.newCounts  = '0;
        bus.peak_valid = 1'b0;
        bus.peak_pixel = '0;
        bus.peak_bin   = '0;
        bus.peak_count = '0;
        bus.peak_hit   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clr_d   = clear_en;
                    thr_d   = threshold;
                    pix_d   = '0;
                    bin_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                busy         = 1'b1;
                bus.rEnable  = 1'b1;
                bus.readFlag = 1'b1;
                bus.raddr    = bin_addr(pix_q, bin_q);
                vld_d        = 1'b1;
                dbin_d       = bin_q;
                bin_d        = bin_q + BIN_W'(1);
                if (bin_q == LAST_BIN) begin
                    bin_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                busy           = 1'b1;
                bus.peak_valid = 1'b1;
                bus.peak_pixel = pix_q;
                bus.peak_bin   = mbin_q;
                bus.peak_count = max_q;
                bus.peak_hit   = (max_q >= thr_q);
                if (bus.peak_ready) begin
                    if (pix_q == LAST_PIX) begin
                        state_d = S_DONE;
                    end else begin
                        pix_d   = pix_q + PIX_W'(1);
                        bin_d   = '0;
                        state_d = S_SCAN;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Read data lands one cycle after its address; strict '>' keeps the lowest bin on ties.
        if (vld_q) begin
            if (dbin_q == '0 || bus.counts > max_q) begin
                max_d  = bus.counts;
                mbin_d = dbin_q;
            end
            if (clr_q) begin
                bus.wEnable   = 1'b1;
                bus.writeFlag = 1'b1;
                bus.waddr     = bin_addr(pix_q, dbin_q);
            end
        end
    end

endmodule

// File: tb/tb_sifh_hist_reader.sv
// Directed bench for sifh_hist_reader: small RAM model, result monitor and
// hand-computed peak/clear expectations.
`timescale 1ns/1ps
module tb_sifh_hist_reader;
    localparam int NB = 4, PEAK_MAX = 8, BIN_NUM_PER_HIS = 8;
    localparam int PIXEL_NUM_PER_RAM = 2, PIX_W = 1, BIN_W = 3;

    typedef struct packed {
        logic [PIX_W-1:0]    pix;
        logic [BIN_W-1:0]    bin;
        logic [PEAK_MAX-1:0] cnt;
        logic                hit;
    } res_t;

    logic clk = 1'b0, res = 1'b0, start = 1'b0, clear_en = 1'b0;
    logic [7:0] threshold = '0;
    logic busy, done;

    sifh_hist_reader_if #(.NB(NB), .PEAK_MAX(PEAK_MAX), .PIX_W(PIX_W), .BIN_W(BIN_W)) bus ();

    sifh_hist_reader #(
        .NB(NB), .PEAK_MAX(PEAK_MAX), .BIN_NUM_PER_HIS(BIN_NUM_PER_HIS),
        .PIXEL_NUM_PER_RAM(PIXEL_NUM_PER_RAM), .PIX_W(PIX_W), .BIN_W(BIN_W)
    ) dut (
        .clk(clk), .res(res), .start(start), .clear_en(clear_en),
        .threshold(threshold), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (bus.readFlag && bus.rEnable) bus.counts <= mem[bus.raddr];
        if (bus.writeFlag && bus.wEnable) mem[bus.waddr] = bus.newCounts;
    end

    int n_cmp = 0, n_err = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    res_t rq[$];
    int nwr = 0, ndone = 0;
    logic prev_rd = 1'b0;
    logic [3:0] prev_raddr = '0;

    always begin
        @(negedge clk);
        #1;
        if (res) begin
            if (bus.peak_valid && bus.peak_ready)
                rq.push_back('{pix: bus.peak_pixel, bin: bus.peak_bin,
                               cnt: bus.peak_count, hit: bus.peak_hit});
            if (done) ndone++;
            if (bus.wEnable && bus.writeFlag) begin
                chk("wr_follow", 32'({prev_rd, bus.waddr, bus.newCounts}),
                    32'({1'b1, prev_raddr, 8'd0}));
                nwr++;
            end
            prev_rd    = bus.rEnable && bus.readFlag;
            prev_raddr = bus.raddr;
        end
    end

    function automatic logic [31:0] rget(input int i);
        if (i < rq.size()) return 32'(rq[i]);
        return 32'hffff_ffff;
    endfunction

    function automatic logic [31:0] rexp(input logic p, input logic [2:0] b,
                                         input logic [7:0] c, input logic h);
        return 32'({p, b, c, h});
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({busy, done, bus.raddr, bus.rEnable, bus.readFlag, bus.waddr,
                    bus.wEnable, bus.writeFlag}) ^
               32'({bus.newCounts, bus.peak_valid, bus.peak_pixel, bus.peak_bin,
                    bus.peak_count, bus.peak_hit});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mem_fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic load_t1();
        mem_fill(8'd0);
        mem[1] = 8'd1; mem[2] = 8'd9; mem[3] = 8'd3;
        mem[13] = 8'd200;
    endtask

    task automatic pulse_start(input logic clr, input logic [7:0] thr);
        rq.delete();
        nwr = 0;
        ndone = 0;
        @(negedge clk);
        start = 1'b1; clear_en = clr; threshold = thr;
        @(negedge clk);
        start = 1'b0; clear_en = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (ndone == 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (ndone == 0) chk("done_timeout", 32'd0, 32'd1);
        tick(4);
    endtask

    initial begin
        bus.peak_ready = 1'b1;
        mem_fill(8'd0);
        tick(2);
        chk("reset_outs", all_outs(), 32'd0);
        chk("reset_busy_done", 32'({busy, done, bus.peak_valid, bus.peak_hit}), 32'd0);
        res = 1'b1;
        tick(2);

        // single peak, no clear
        load_t1();
        pulse_start(1'b0, 8'd4);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done();
        chk("t1_p0", rget(0), rexp(1'b0, 3'd2, 8'd9, 1'b1));
        chk("t1_p1", rget(1), rexp(1'b1, 3'd5, 8'd200, 1'b1));
        chk("t1_nres", rq.size(), 32'd2);
        chk("t1_ndone", ndone, 32'd1);
        chk("t1_nwr", nwr, 32'd0);
        chk("t1_mem_kept", 32'({mem[2], mem[13]}), 32'({8'd9, 8'd200}));
        chk("t1_idle", 32'({busy, done}), 32'd0);

        // ties keep lowest bin; saturated counts compare normally
        mem_fill(8'd0);
        mem[1] = 8'd5; mem[6] = 8'd5;
        mem[11] = 8'd255; mem[12] = 8'd255;
        pulse_start(1'b0, 8'd0);
        wait_done();
        chk("t2_tie", rget(0), rexp(1'b0, 3'd1, 8'd5, 1'b1));
        chk("t2_sat", rget(1), rexp(1'b1, 3'd3, 8'd255, 1'b1));

        // threshold boundary and all-zero histogram
        mem_fill(8'd0);
        mem[7] = 8'd3;
        pulse_start(1'b0, 8'd4);
        wait_done();
        chk("t5_below", rget(0), rexp(1'b0, 3'd7, 8'd3, 1'b0));
        chk("t5_zero", rget(1), rexp(1'b1, 3'd0, 8'd0, 1'b0));

        // clear: every bin zeroed right behind its read
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
        pulse_start(1'b1, 8'd0);
        wait_done();
        chk("t4_p0", rget(0), rexp(1'b0, 3'd7, 8'd8, 1'b1));
        chk("t4_p1", rget(1), rexp(1'b1, 3'd7, 8'd16, 1'b1));
        chk("t4_nwr", nwr, 32'd16);
        begin
            int nz = 0;
            for (int i = 0; i < 16; i++) if (mem[i] != 8'd0) nz++;
            chk("t4_mem_zero", nz, 32'd0);
        end

        // backpressure in EMIT
        load_t1();
        bus.peak_ready = 1'b0;
        pulse_start(1'b1, 8'd4);
        begin
            int k = 0;
            while (!bus.peak_valid && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        chk("t3_valid", 32'(bus.peak_valid), 32'd1);
        chk("t3_latency", 32'(nwr), 32'd8);
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold", 32'({bus.peak_valid, bus.peak_pixel, bus.peak_bin, bus.peak_count,
                                bus.peak_hit, bus.rEnable, bus.wEnable}),
                32'({1'b1, 1'b0, 3'd2, 8'd9, 1'b1, 1'b0, 1'b0}));
            if (c < 4) @(negedge clk);
        end
        bus.peak_ready = 1'b1;
        @(negedge clk);
        chk("t3_next_read", 32'({bus.peak_valid, bus.rEnable, bus.raddr}),
            32'({1'b0, 1'b1, 4'd8}));
        wait_done();
        chk("t3_p0", rget(0), rexp(1'b0, 3'd2, 8'd9, 1'b1));
        chk("t3_p1", rget(1), rexp(1'b1, 3'd5, 8'd200, 1'b1));
        chk("t3_nwr", nwr, 32'd16);

        // reset mid-scan at pixel1 bin3
        load_t1();
        pulse_start(1'b0, 8'd4);
        begin
            int k = 0;
            while (!(bus.rEnable && bus.raddr == 4'd11) && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        chk("t6_reach", 32'({bus.rEnable, bus.raddr}), 32'({1'b1, 4'd11}));
        res = 1'b0;
        @(negedge clk);
        chk("t6_outs", all_outs(), 32'd0);
        chk("t6_flags", 32'({busy, bus.peak_valid, bus.wEnable, bus.rEnable}), 32'd0);
        tick(2);
        res = 1'b1;
        tick(20);
        chk("t6_nres", rq.size(), 32'd1);
        chk("t6_ndone", ndone, 32'd0);

        // restart; a second start while busy must be ignored
        pulse_start(1'b0, 8'd4);
        tick(3);
        start = 1'b1; clear_en = 1'b1; threshold = 8'd255;
        @(negedge clk);
        start = 1'b0; clear_en = 1'b0; threshold = 8'd0;
        wait_done();
        chk("t6_p0", rget(0), rexp(1'b0, 3'd2, 8'd9, 1'b1));
        chk("t6_p1", rget(1), rexp(1'b1, 3'd5, 8'd200, 1'b1));
        chk("t6_nwr", nwr, 32'd0);
        chk("t6_ndone2", ndone, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
